// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package riscv_fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // True when pc addresses a word inside an instruction memory of 'words' 32-bit words.
  function automatic logic pc_in_range(input logic [XLEN-1:0] pc, input int unsigned words);
    logic [XLEN-1:0] limit;
    limit = XLEN'(words) << 2;
    return pc < limit;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// The head is held in dedicated registers so decode sees a flop output;
// count includes the head entry. The head holds its last value when the
// queue empties, and shows {0, NOP} after reset or flush.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(QDEPTH):0]  count,
  output logic                     head_valid,
  output fetch_entry_t             head_entry
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(QDEPTH);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          head_valid_q, head_valid_d;
  fetch_entry_t  head_entry_q, head_entry_d;

  logic          do_pop;
  logic          do_push;
  logic [CW-1:0] remain;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && !flush && ((count_q < FULL_C) || do_pop);
  assign remain  = count_q - CW'(do_pop);

  assign count      = count_q;
  assign head_valid = head_valid_q;
  assign head_entry = head_entry_q;

  // Next pointers, occupancy and head contents.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_entry_d = head_entry_q;
    if (flush) begin
      rd_ptr_d           = '0;
      wr_ptr_d           = '0;
      count_d            = '0;
      head_valid_d       = 1'b0;
      head_entry_d.pc    = '0;
      head_entry_d.instr = NOP_INSTR;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d      = remain + CW'(do_push);
      head_valid_d = (count_d != '0);
      // New head is the pushed entry when nothing else remains, otherwise
      // the oldest stored entry after the pop.
      if (count_d != '0)
        head_entry_d = (remain == '0) ? push_entry : mem_q[rd_ptr_d];
    end
  end

  // Entry storage, written at the tail; no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      head_valid_q       <= 1'b0;
      head_entry_q.pc    <= '0;
      head_entry_q.instr <= NOP_INSTR;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_entry_q <= head_entry_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory,
// queues {pc, instr} toward decode and handles redirects and fetch faults.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(QDEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            fetch_fault_q, fetch_fault_d;

  logic [CW-1:0]   q_count;
  logic            head_valid;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            pc_ok;
  logic            redir_misaligned;
  logic [XLEN-1:0] redir_target;

  assign imem_pc     = fetch_pc_q;
  assign if_valid    = head_valid;
  assign if_instr    = head_entry.instr;
  assign if_pc       = head_entry.pc;
  assign fetch_fault = fetch_fault_q;

  assign pc_ok            = pc_in_range(fetch_pc_q, IMEM_WORDS);
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_target     = {redirect_pc[63:2], 2'b00};

  assign pop  = head_valid && if_ready;
  assign push = !halt && !fetch_fault_q && !redirect_valid && pc_ok &&
                ((q_count < FULL_C) || pop);

  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = imem_instr;

  // Next PC and fault state; a redirect overrides everything else.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_fault_d = fetch_fault_q;
    if (redirect_valid) begin
      fetch_pc_d = redir_target;
      if (redir_misaligned)
        fetch_fault_d = 1'b1;
      else if (pc_in_range(redir_target, IMEM_WORDS))
        fetch_fault_d = 1'b0;
    end else begin
      if (push)   fetch_pc_d    = fetch_pc_q + 64'd4;
      if (!pc_ok) fetch_fault_d = 1'b1;
    end
  end

  // PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= {RESET_PC[63:2], 2'b00};
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (q_count),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fetch_fault;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(
    .RESET_PC   (64'h0),
    .IMEM_WORDS (128),
    .QDEPTH     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a simple function of the word address.
  function automatic logic [31:0] ins(input logic [63:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  assign imem_instr = ins(imem_pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(if_valid), 64'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, 64'(if_instr), 64'(ins(pc)));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_pc"}, imem_pc, 64'h0);
    chk({tag, "_valid"}, 64'(if_valid), 64'd0);
    chk({tag, "_instr"}, 64'(if_instr), 64'h13);
    chk({tag, "_pc"}, if_pc, 64'h0);
    chk({tag, "_fault"}, 64'(fetch_fault), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    halt = 1'b0;
    if_ready = 1'b0;

    // Reset state
    step();
    chk_reset("rst");
    $display("[TB] reset: imem_pc=%h if_valid=%0b", imem_pc, if_valid);

    // Streaming with if_ready held high
    rst_n = 1'b1;
    if_ready = 1'b1;
    step();
    chk("s1_imem0", imem_pc, 64'h4);
    chk_head("s1_h0", 64'h0);
    step();
    chk("s1_imem1", imem_pc, 64'h8);
    chk_head("s1_h1", 64'h4);
    step();
    chk("s1_imem2", imem_pc, 64'hC);
    chk_head("s1_h2", 64'h8);
    $display("[TB] stream: if_pc=%h imem_pc=%h", if_pc, imem_pc);

    // Reset mid-operation
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    $display("[TB] mid-op reset: if_valid=%0b if_instr=%h", if_valid, if_instr);

    // Backpressure: decode stalled for 5 cycles from PC 0
    rst_n = 1'b1;
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_imem_hold", imem_pc, 64'h8);
    chk_head("bp_h_hold", 64'h0);
    if_ready = 1'b1;
    step();
    chk_head("bp_h1", 64'h4);
    chk("bp_imem1", imem_pc, 64'hC);
    step();
    chk_head("bp_h2", 64'h8);
    $display("[TB] backpressure release: if_pc=%h imem_pc=%h", if_pc, imem_pc);

    // Redirect to 0x40 while the queue is full
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 64'(if_valid), 64'd0);
    chk("rd_instr_nop", 64'(if_instr), 64'h13);
    chk("rd_imem", imem_pc, 64'h40);
    step();
    chk_head("rd_h0", 64'h40);
    step();
    chk_head("rd_h1", 64'h44);
    $display("[TB] redirect 0x40: if_pc=%h", if_pc);

    // Misaligned redirect sets the fault and blocks fetch
    redirect_valid = 1'b1;
    redirect_pc = 64'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_fault", 64'(fetch_fault), 64'd1);
    chk("mis_valid", 64'(if_valid), 64'd0);
    step();
    step();
    chk("mis_valid_hold", 64'(if_valid), 64'd0);
    chk("mis_imem_hold", imem_pc, 64'h40);
    chk("mis_fault_sticky", 64'(fetch_fault), 64'd1);
    $display("[TB] misaligned redirect: fault=%0b imem_pc=%h", fetch_fault, imem_pc);

    // Aligned in-range redirect clears the fault
    redirect_valid = 1'b1;
    redirect_pc = 64'h10;
    step();
    redirect_valid = 1'b0;
    chk("clr_fault", 64'(fetch_fault), 64'd0);
    chk("clr_imem", imem_pc, 64'h10);
    step();
    chk_head("clr_h0", 64'h10);
    $display("[TB] fault clear: if_pc=%h", if_pc);

    // Run off the end of instruction memory
    redirect_valid = 1'b1;
    redirect_pc = 64'h1F8;
    step();
    redirect_valid = 1'b0;
    step();
    chk_head("oor_h0", 64'h1F8);
    step();
    chk_head("oor_h1", 64'h1FC);
    chk("oor_imem", imem_pc, 64'h200);
    step();
    chk("oor_fault", 64'(fetch_fault), 64'd1);
    chk("oor_valid", 64'(if_valid), 64'd0);
    chk("oor_last_pc", if_pc, 64'h1FC);
    chk("oor_imem_hold", imem_pc, 64'h200);
    step();
    chk("oor_valid_hold", 64'(if_valid), 64'd0);
    $display("[TB] out of range: fault=%0b last if_pc=%h", fetch_fault, if_pc);

    // Reset clears the sticky fault
    rst_n = 1'b0;
    step();
    chk_reset("rst2");
    rst_n = 1'b1;
    step();
    chk_head("hl_h0", 64'h0);
    chk("hl_imem0", imem_pc, 64'h4);

    // Halt for 3 cycles: queue drains, PC frozen
    halt = 1'b1;
    step();
    chk("hl_valid0", 64'(if_valid), 64'd0);
    chk("hl_imem_a", imem_pc, 64'h4);
    step();
    step();
    chk("hl_imem_b", imem_pc, 64'h4);
    chk("hl_valid1", 64'(if_valid), 64'd0);
    halt = 1'b0;
    step();
    chk_head("hl_resume", 64'h4);
    chk("hl_imem_resume", imem_pc, 64'h8);
    $display("[TB] halt resume: if_pc=%h imem_pc=%h", if_pc, imem_pc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
